// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer: picks the next control state from the N field,
// holds on memory waits, traps stuck waits and flags the reserved N mode.
module microprogram_sequencer #(
  parameter int         TIMEOUT     = 64,
  parameter logic [6:0] TRAP_STATE  = 7'd127,
  parameter logic [6:0] RESET_STATE = 7'd0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] state_sel_i,
  input  logic [2:0] n_i,
  input  logic [6:0] cr_i,
  input  logic       inv_i,
  input  logic       cond_i,
  input  logic       moc_i,
  output logic [6:0] state_o,
  output logic       stall_o,
  output logic       mem_timeout_o,
  output logic       illegal_n_o
);

  localparam logic [2:0] N_ENCODE   = 3'b000;
  localparam logic [2:0] N_JUMP     = 3'b001;
  localparam logic [2:0] N_INCR     = 3'b010;
  localparam logic [2:0] N_COND     = 3'b011;
  localparam logic [2:0] N_WAIT_INC = 3'b100;
  localparam logic [2:0] N_WAIT_JMP = 3'b101;
  localparam logic [2:0] N_RESTART  = 3'b110;
  localparam logic [2:0] N_RSVD     = 3'b111;
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  logic [6:0] state_q, state_d, state_inc;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       illegal_n_q, illegal_n_d;
  logic       hold, cond_t, moc_t;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RESET_STATE;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      illegal_n_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      illegal_n_q   <= illegal_n_d;
    end
  end

  always_comb begin
    state_inc     = state_q + 7'd1;
    cond_t        = cond_i ^ inv_i;
    moc_t         = moc_i ^ inv_i;
    hold          = 1'b0;
    state_d       = RESET_STATE;
    wait_cnt_d    = 8'd0;
    mem_timeout_d = 1'b0;
    case (n_i)
      N_ENCODE:   state_d = state_sel_i;
      N_JUMP:     state_d = cr_i;
      N_INCR:     state_d = state_inc;
      N_COND:     state_d = cond_t ? cr_i : state_inc;
      N_WAIT_INC: begin
        hold    = ~moc_t;
        state_d = moc_t ? state_inc : state_q;
      end
      N_WAIT_JMP: begin
        hold    = ~moc_t;
        state_d = moc_t ? cr_i : state_q;
      end
      N_RESTART:  state_d = RESET_STATE;
      // Reserved and unknown N both fall back to the reset state.
      default:    state_d = RESET_STATE;
    endcase
    if (hold) begin
      if (wait_cnt_q == WAIT_LAST) begin
        state_d       = TRAP_STATE;
        mem_timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
    illegal_n_d = (n_i == N_RSVD);
  end

  always_comb begin
    state_o       = state_q;
    stall_o       = hold;
    mem_timeout_o = mem_timeout_q;
    illegal_n_o   = illegal_n_q;
  end

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Scenario bench for microprogram_sequencer (TIMEOUT=4): expectations go into
// a scoreboard queue as stimulus is driven and are popped after each edge.
module tb_microprogram_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] state_sel_i, cr_i, state_o;
  logic [2:0] n_i;
  logic       inv_i, cond_i, moc_i;
  logic       stall_o, mem_timeout_o, illegal_n_o;
  logic       stall_s;

  always #5 clk = ~clk;

  microprogram_sequencer #(.TIMEOUT(4), .TRAP_STATE(7'd127), .RESET_STATE(7'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .state_sel_i(state_sel_i), .n_i(n_i), .cr_i(cr_i),
    .inv_i(inv_i), .cond_i(cond_i), .moc_i(moc_i), .state_o(state_o),
    .stall_o(stall_o), .mem_timeout_o(mem_timeout_o), .illegal_n_o(illegal_n_o)
  );

  typedef struct packed {
    logic [2:0] n; logic [6:0] sel; logic [6:0] cr;
    logic inv; logic cond; logic moc;
    logic [6:0] st; logic stall; logic mt; logic il;
  } vec_t;
  typedef struct packed { logic [6:0] st; logic stall; logic mt; logic il; } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [2:0] n, input logic [6:0] sel, input logic [6:0] cr,
                              input logic inv, input logic cond, input logic moc,
                              input logic [6:0] st, input logic stall, input logic mt,
                              input logic il);
    vec_t v;
    v.n = n; v.sel = sel; v.cr = cr; v.inv = inv; v.cond = cond; v.moc = moc;
    v.st = st; v.stall = stall; v.mt = mt; v.il = il;
    return v;
  endfunction

  // Drive on the falling edge, capture Stall mid-phase, land 1 ns after the rising edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    n_i = v.n; state_sel_i = v.sel; cr_i = v.cr;
    inv_i = v.inv; cond_i = v.cond; moc_i = v.moc;
    #2 stall_s = stall_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    vec_t v[$];
    exp_t e;
    rst_n = 1'b0; n_i = 3'b110; state_sel_i = '0; cr_i = '0;
    inv_i = 1'b0; cond_i = 1'b0; moc_i = 1'b0;
    #12;
    n_vec++;
    if ({state_o, mem_timeout_o, illegal_n_o} !== {7'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got st=%0d mt=%b il=%b, want st=0 mt=0 il=0",
               state_o, mem_timeout_o, illegal_n_o);
    end
    @(negedge clk) rst_n = 1'b1;
    v.push_back(mk(3'd1, 7'd0, 7'd45, 0, 0, 0, 7'd45, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL reset_setup[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
    @(negedge clk);
    n_i = 3'b110;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state_o, mem_timeout_o, illegal_n_o} !== {7'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_45: got st=%0d mt=%b il=%b, want st=0 mt=0 il=0",
               state_o, mem_timeout_o, illegal_n_o);
    end
    @(negedge clk) rst_n = 1'b1;
    step(mk(3'd7, 7'd0, 7'd0, 0, 0, 0, 7'd0, 0, 0, 1));
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state_o, illegal_n_o} !== {7'd0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_illegal: got st=%0d il=%b, want st=0 il=0", state_o, illegal_n_o);
    end
    @(negedge clk);
    n_i = 3'b110;
    rst_n = 1'b1;
  endtask

  task automatic test_encode_jump_incr;
    vec_t v[$];
    exp_t e;
    v.push_back(mk(3'd0, 7'd33, 7'd0,   0, 0, 0, 7'd33,  0, 0, 0));
    v.push_back(mk(3'd1, 7'd0,  7'd90,  0, 0, 0, 7'd90,  0, 0, 0));
    v.push_back(mk(3'd2, 7'd0,  7'd0,   0, 0, 0, 7'd91,  0, 0, 0));
    v.push_back(mk(3'd1, 7'd0,  7'd127, 0, 0, 0, 7'd127, 0, 0, 0));
    v.push_back(mk(3'd2, 7'd5,  7'd9,   0, 0, 0, 7'd0,   0, 0, 0));
    v.push_back(mk(3'd6, 7'd5,  7'd9,   0, 0, 0, 7'd0,   0, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL encode_jump_incr[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
  endtask

  task automatic test_cond;
    vec_t v[$];
    exp_t e;
    v.push_back(mk(3'd1, 7'd0, 7'd5,  0, 0, 0, 7'd5,  0, 0, 0));
    v.push_back(mk(3'd3, 7'd0, 7'd20, 0, 1, 0, 7'd20, 0, 0, 0));
    v.push_back(mk(3'd1, 7'd0, 7'd5,  0, 0, 0, 7'd5,  0, 0, 0));
    v.push_back(mk(3'd3, 7'd0, 7'd20, 1, 1, 0, 7'd6,  0, 0, 0));
    v.push_back(mk(3'd3, 7'd0, 7'd20, 1, 0, 0, 7'd20, 0, 0, 0));
    v.push_back(mk(3'd3, 7'd0, 7'd40, 0, 0, 1, 7'd21, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL cond[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
  endtask

  task automatic test_wait_inc_timeout;
    vec_t v[$];
    exp_t e;
    v.push_back(mk(3'd1, 7'd0, 7'd10, 0, 0, 0, 7'd10, 0, 0, 0));
    for (int k = 0; k < 3; k++) v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd10, 1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd127, 1, 1, 0));
    v.push_back(mk(3'd1, 7'd0, 7'd10, 0, 0, 0, 7'd10, 0, 0, 0));
    for (int k = 0; k < 3; k++) v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd10, 1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 1, 7'd11, 0, 0, 0));
    for (int k = 0; k < 3; k++) v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd11, 1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd127, 1, 1, 0));
    v.push_back(mk(3'd2, 7'd0, 7'd0, 0, 0, 0, 7'd0, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL wait_inc_timeout[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
  endtask

  task automatic test_wait_jmp;
    vec_t v[$];
    exp_t e;
    v.push_back(mk(3'd1, 7'd0, 7'd40, 0, 0, 0, 7'd40, 0, 0, 0));
    v.push_back(mk(3'd5, 7'd0, 7'd50, 0, 0, 0, 7'd40, 1, 0, 0));
    v.push_back(mk(3'd5, 7'd0, 7'd50, 0, 0, 0, 7'd40, 1, 0, 0));
    v.push_back(mk(3'd5, 7'd0, 7'd50, 0, 0, 1, 7'd50, 0, 0, 0));
    v.push_back(mk(3'd5, 7'd0, 7'd60, 1, 0, 1, 7'd50, 1, 0, 0));
    v.push_back(mk(3'd5, 7'd0, 7'd60, 1, 0, 0, 7'd60, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL wait_jmp[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
      if (i == 3) begin
        n_vec++;
        if (dut.wait_cnt_q !== 8'd0) begin
          n_err++;
          $display("FAIL wait_jmp_cnt_clear: got wait_cnt=%0d, want 0", dut.wait_cnt_q);
        end
      end
    end
  endtask

  task automatic test_illegal;
    vec_t v[$];
    exp_t e;
    v.push_back(mk(3'd1, 7'd0, 7'd8, 0, 0, 0, 7'd8, 0, 0, 0));
    v.push_back(mk(3'd7, 7'd0, 7'd9, 0, 0, 0, 7'd0, 0, 0, 1));
    v.push_back(mk(3'd2, 7'd0, 7'd9, 0, 0, 0, 7'd1, 0, 0, 0));
    v.push_back(mk(3'd7, 7'd0, 7'd9, 0, 0, 0, 7'd0, 0, 0, 1));
    v.push_back(mk(3'd7, 7'd0, 7'd9, 0, 0, 0, 7'd0, 0, 0, 1));
    v.push_back(mk(3'd0, 7'd3, 7'd9, 0, 0, 0, 7'd3, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL illegal[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
  endtask

  // Reset mid-wait must clear the wait count: after release the state-0 wait
  // gets a full four hold edges (one idle edge plus three steps) before trapping.
  task automatic test_reset_midwait;
    vec_t v[$];
    exp_t e;
    v.push_back(mk(3'd1, 7'd0, 7'd10, 0, 0, 0, 7'd10, 0, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd10, 1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd10, 1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd10, 1, 0, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL midwait_pre[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state_o, mem_timeout_o} !== {7'd0, 1'b0}) begin
      n_err++;
      $display("FAIL midwait_reset: got st=%0d mt=%b, want st=0 mt=0", state_o, mem_timeout_o);
    end
    @(negedge clk) rst_n = 1'b1;
    v.delete();
    v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd0,   1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd0,   1, 0, 0));
    v.push_back(mk(3'd4, 7'd0, 7'd0, 0, 0, 0, 7'd127, 1, 1, 0));
    foreach (v[i]) begin
      sb.push_back(exp_t'({v[i].st, v[i].stall, v[i].mt, v[i].il}));
      step(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL midwait_post[%0d]: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 i, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state_o, mem_timeout_o} !== {7'd0, 1'b0}) begin
      n_err++;
      $display("FAIL trap_reset: got st=%0d mt=%b, want st=0 mt=0", state_o, mem_timeout_o);
    end
    @(negedge clk);
    n_i = 3'b110;
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    vec_t       v;
    exp_t       e;
    logic [6:0] m_st, m_inc;
    logic [7:0] m_cnt;
    logic       m_hold;
    @(negedge clk);
    n_i = 3'b110;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_st = 7'd0;
    m_cnt = 8'd0;
    for (int k = 0; k < 300; k++) begin
      v.n    = 3'($urandom_range(0, 7));
      v.sel  = 7'($urandom);
      v.cr   = 7'($urandom);
      v.inv  = ($urandom_range(0, 4) == 0);
      v.cond = 1'($urandom);
      v.moc  = ($urandom_range(0, 3) == 0);
      m_inc  = m_st + 7'd1;
      m_hold = 1'b0;
      v.mt   = 1'b0;
      case (v.n)
        3'd0: v.st = v.sel;
        3'd1: v.st = v.cr;
        3'd2: v.st = m_inc;
        3'd3: v.st = (v.cond ^ v.inv) ? v.cr : m_inc;
        3'd4: begin v.st = (v.moc ^ v.inv) ? m_inc : m_st; m_hold = !(v.moc ^ v.inv); end
        3'd5: begin v.st = (v.moc ^ v.inv) ? v.cr : m_st;  m_hold = !(v.moc ^ v.inv); end
        default: v.st = 7'd0;
      endcase
      if (!m_hold) m_cnt = 8'd0;
      else if (m_cnt == 8'd3) begin
        v.st = 7'd127;
        v.mt = 1'b1;
        m_cnt = 8'd0;
      end else m_cnt = m_cnt + 8'd1;
      v.stall = m_hold;
      v.il = (v.n == 3'd7);
      m_st = v.st;
      sb.push_back(exp_t'({v.st, v.stall, v.mt, v.il}));
      step(v);
      e = sb.pop_front();
      n_vec++;
      if ({state_o, stall_s, mem_timeout_o, illegal_n_o} !== e) begin
        n_err++;
        $display("FAIL random[%0d] n=%0d: got st=%0d stall=%b mt=%b il=%b, want st=%0d stall=%b mt=%b il=%b",
                 k, v.n, state_o, stall_s, mem_timeout_o, illegal_n_o, e.st, e.stall, e.mt, e.il);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode_jump_incr();
    test_cond();
    test_wait_inc_timeout();
    test_wait_jmp();
    test_illegal();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
